// File: rtl/xlr8_text_pkg.sv
// ============================================================================
// Module      : xlr8_text_pkg
// Description : Shared constants, attribute layout and CGA palette for the
//               text-mode renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xlr8_text_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int LAT    = 5;

    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } attr_t;

    // Entry 15 first so that CGA_PALETTE[i] selects palette index i.
    localparam logic [15:0][23:0] CGA_PALETTE = {
        24'hFFFFFF, 24'hFFFF55, 24'hFF55FF, 24'hFF5555,
        24'h55FFFF, 24'h55FF55, 24'h5555FF, 24'h555555,
        24'hAAAAAA, 24'hAA5500, 24'hAA00AA, 24'hAA0000,
        24'h00AAAA, 24'h00AA00, 24'h0000AA, 24'h000000
    };

endpackage

`default_nettype wire

// File: rtl/xlr8_font_rom.sv
// ============================================================================
// Module      : xlr8_font_rom
// Description : 4096x8 glyph ROM addressed by {char, line}, 1-cycle read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xlr8_font_rom (
    input  logic        clk_pixel,
    input  logic        rstn,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);

    // Glyph table; code points not listed render as blank cells.
    function automatic logic [7:0] glyph_row(input logic [11:0] a);
        logic [7:0] ch;
        logic [3:0] ln;
        ch = a[11:4];
        ln = a[3:0];
        glyph_row = 8'h00;
        case (ch)
            8'h01: glyph_row = 8'h81;
            8'hDB: glyph_row = 8'hFF;
            8'h41: begin
                case (ln)
                    4'd2:                      glyph_row = 8'h10;
                    4'd3:                      glyph_row = 8'h38;
                    4'd4:                      glyph_row = 8'h6C;
                    4'd5, 4'd6:                glyph_row = 8'hC6;
                    4'd7:                      glyph_row = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11:  glyph_row = 8'hC6;
                    default:                   glyph_row = 8'h00;
                endcase
            end
            default: glyph_row = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            o_data <= 8'h00;
        end else begin
            o_data <= glyph_row(i_addr);
        end
    end

endmodule

`default_nettype wire

// File: rtl/xlr8_text_renderer.sv
// ============================================================================
// Module      : xlr8_text_renderer
// Description : Fetches char/attr bytes per 8-pixel cell and serialises glyph
//               rows into RGB with blink and hardware cursor (latency 5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xlr8_text_renderer
    import xlr8_text_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        clk_pixel,
    input  logic        rstn,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic        de,
    input  logic        vsync_pulse,
    input  logic        cursor_en,
    input  logic [12:0] cursor_addr,
    output logic [12:0] ram_address,
    output logic        ram_char_re,
    output logic        ram_attr_re,
    input  logic [7:0]  ram_char_data,
    input  logic [7:0]  ram_attr_data,
    output logic [23:0] rgb,
    output logic        de_out
);

    localparam int          C_LINE_W = $clog2(CHAR_H);
    localparam logic [5:0]  C_ROWS   = 6'(ROWS);
    localparam logic [12:0] C_CELLS  = 13'(COLS * ROWS);

    logic                  w_cell_start;
    logic [12:0]           w_row;
    logic [12:0]           w_col;
    logic [12:0]           w_addr;
    logic [7:0]            w_glyph;

    logic                  r_v1, r_v2, r_v3, r_v4;
    logic [C_LINE_W-1:0]   r_line1, r_line2, r_line3;
    logic [12:0]           r_idx2, r_idx3;
    logic [7:0]            r_char3;
    attr_t                 r_attr3, r_attr4;
    logic                  r_hit4;

    logic [CHAR_W-1:0]     r_shift;
    logic [2:0]            r_left;
    logic [3:0]            r_fg, r_bg;
    logic                  r_cur;
    logic [LAT-1:0]        r_de;
    logic [BLINK_LOG2-1:0] r_frame;

    assign w_cell_start = de && (cx[2:0] == 3'd0) && (cy[9:4] < C_ROWS);
    assign w_row        = {7'd0, cy[9:4]};
    assign w_col        = {6'd0, cx[9:3]};

    generate
        if (COLS == 80) begin : g_addr_80
            assign w_addr = (w_row << 6) + (w_row << 4) + w_col;
        end else begin : g_addr_mul
            assign w_addr = (w_row * 13'(COLS)) + w_col;
        end
    endgenerate

    xlr8_font_rom u_font_rom (
        .clk_pixel (clk_pixel),
        .rstn      (rstn),
        .i_addr    ({r_char3, r_line3}),
        .o_data    (w_glyph)
    );

    // Fetch pipeline S1..S4: address issue, RAM capture, font address, glyph.
    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            ram_address <= 13'd0;
            ram_char_re <= 1'b0;
            ram_attr_re <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_v4        <= 1'b0;
            r_line1     <= '0;
            r_line2     <= '0;
            r_line3     <= '0;
            r_idx2      <= 13'd0;
            r_idx3      <= 13'd0;
            r_char3     <= 8'd0;
            r_attr3     <= '0;
            r_attr4     <= '0;
            r_hit4      <= 1'b0;
        end else begin
            ram_char_re <= w_cell_start;
            ram_attr_re <= w_cell_start;
            if (w_cell_start) begin
                ram_address <= w_addr;
            end
            r_v1    <= w_cell_start;
            r_line1 <= cy[C_LINE_W-1:0];
            r_v2    <= r_v1;
            r_line2 <= r_line1;
            r_idx2  <= ram_address;
            r_v3    <= r_v2;
            r_line3 <= r_line2;
            r_idx3  <= r_idx2;
            r_char3 <= ram_char_data;
            r_attr3 <= attr_t'(ram_attr_data);
            r_v4    <= r_v3;
            r_attr4 <= r_attr3;
            r_hit4  <= cursor_en && (r_idx3 == cursor_addr) && (cursor_addr < C_CELLS)
                       && (r_line3 >= C_LINE_W'(CHAR_H - 2));
        end
    end

    logic       w_load;
    logic       w_blink;
    logic [3:0] w_new_fg, w_new_bg;
    logic       w_new_cur;
    logic       w_bit, w_cur, w_active;
    logic [3:0] w_fg, w_bg, w_pix_idx;

    assign w_load    = r_v4;
    assign w_blink   = r_frame[BLINK_LOG2-1];
    assign w_new_bg  = {1'b0, r_attr4.bg};
    assign w_new_fg  = (r_attr4.blink && w_blink) ? w_new_bg : r_attr4.fg;
    assign w_new_cur = r_hit4 && !w_blink;
    assign w_bit     = w_load ? w_glyph[CHAR_W-1] : r_shift[CHAR_W-1];
    assign w_cur     = w_load ? w_new_cur : r_cur;
    assign w_fg      = w_load ? w_new_fg  : r_fg;
    assign w_bg      = w_load ? w_new_bg  : r_bg;
    assign w_active  = w_load || (r_left != 3'd0);
    assign w_pix_idx = (w_bit || w_cur) ? w_fg : w_bg;

    // A fresh glyph load always wins over whatever is left in the shifter.
    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
            r_left  <= 3'd0;
            r_fg    <= 4'd0;
            r_bg    <= 4'd0;
            r_cur   <= 1'b0;
            rgb     <= 24'd0;
        end else begin
            if (w_load) begin
                r_shift <= w_glyph << 1;
                r_left  <= 3'd7;
                r_fg    <= w_new_fg;
                r_bg    <= w_new_bg;
                r_cur   <= w_new_cur;
            end else begin
                r_shift <= r_shift << 1;
                if (r_left != 3'd0) begin
                    r_left <= r_left - 3'd1;
                end
            end
            rgb <= (r_de[LAT-2] && w_active) ? CGA_PALETTE[w_pix_idx] : 24'd0;
        end
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            r_de    <= '0;
            r_frame <= '0;
        end else begin
            r_de <= {r_de[LAT-2:0], de};
            if (vsync_pulse) begin
                r_frame <= r_frame + BLINK_LOG2'(1);
            end
        end
    end

    assign de_out = r_de[LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_xlr8_text_renderer.sv
// ============================================================================
// Module      : tb_xlr8_text_renderer
// Description : Directed self-checking bench for the text renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xlr8_text_renderer;

    logic        clk_pixel;
    logic        rstn;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        de;
    logic        vsync_pulse;
    logic        cursor_en;
    logic [12:0] cursor_addr;
    logic [12:0] ram_address;
    logic        ram_char_re;
    logic        ram_attr_re;
    logic [7:0]  ram_char_data;
    logic [7:0]  ram_attr_data;
    logic [23:0] rgb;
    logic        de_out;

    int total;
    int bad;

    logic [7:0]  char_mem [0:8191];
    logic [7:0]  attr_mem [0:8191];

    logic [23:0] cap_rgb [0:15];
    logic        cap_de  [0:15];
    logic [12:0] cap_addr;
    logic        cap_cre1, cap_are1, cap_re2, cap_de_pre;

    xlr8_text_renderer dut (
        .clk_pixel     (clk_pixel),
        .rstn          (rstn),
        .cx            (cx),
        .cy            (cy),
        .de            (de),
        .vsync_pulse   (vsync_pulse),
        .cursor_en     (cursor_en),
        .cursor_addr   (cursor_addr),
        .ram_address   (ram_address),
        .ram_char_re   (ram_char_re),
        .ram_attr_re   (ram_attr_re),
        .ram_char_data (ram_char_data),
        .ram_attr_data (ram_attr_data),
        .rgb           (rgb),
        .de_out        (de_out)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Port-B model of the char/attr RAMs: registered read on enable.
    always @(posedge clk_pixel) begin
        if (ram_char_re) ram_char_data <= char_mem[ram_address];
        if (ram_attr_re) ram_attr_data <= attr_mem[ram_address];
    end

    task automatic idle(input int n);
        de = 1'b0;
        repeat (n) @(negedge clk_pixel);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            vsync_pulse = 1'b1;
            @(negedge clk_pixel);
            vsync_pulse = 1'b0;
            @(negedge clk_pixel);
        end
    endtask

    // Drive n consecutive active pixels from (x0,y0); capture outputs.
    task automatic run_cells(input logic [9:0] x0, input logic [9:0] y0, input int n);
        de = 1'b1;
        cx = x0;
        cy = y0;
        for (int k = 1; k <= n + 4; k++) begin
            @(negedge clk_pixel);
            if (k == 1) begin
                cap_addr = ram_address;
                cap_cre1 = ram_char_re;
                cap_are1 = ram_attr_re;
            end
            if (k == 2) cap_re2 = ram_char_re | ram_attr_re;
            if (k == 4) cap_de_pre = de_out;
            if (k >= 5) begin
                cap_rgb[k-5] = rgb;
                cap_de[k-5]  = de_out;
            end
            if (k < n) cx = x0 + 10'(k);
            else       de = 1'b0;
        end
        idle(4);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk_pixel);
        total++; if (ram_address !== 13'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", ram_address); end
        total++; if (ram_char_re !== 1'b0) begin bad++; $display("FAIL reset_char_re got=%b want=0", ram_char_re); end
        total++; if (ram_attr_re !== 1'b0) begin bad++; $display("FAIL reset_attr_re got=%b want=0", ram_attr_re); end
        total++; if (rgb !== 24'd0) begin bad++; $display("FAIL reset_rgb got=%h want=000000", rgb); end
        total++; if (de_out !== 1'b0) begin bad++; $display("FAIL reset_de_out got=%b want=0", de_out); end
        rstn = 1'b1;
        idle(3);
    endtask

    task automatic test_first_cell();
        run_cells(10'd0, 10'd0, 8);
        total++; if (cap_addr !== 13'd0) begin bad++; $display("FAIL first_addr got=%0d want=0", cap_addr); end
        total++; if (cap_cre1 !== 1'b1 || cap_are1 !== 1'b1) begin bad++; $display("FAIL first_re got=%b%b want=11", cap_cre1, cap_are1); end
        total++; if (cap_re2 !== 1'b0) begin bad++; $display("FAIL first_re_drop got=%b want=0", cap_re2); end
        total++; if (cap_de_pre !== 1'b0) begin bad++; $display("FAIL first_de_early got=%b want=0", cap_de_pre); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_de[i] !== 1'b1) begin bad++; $display("FAIL first_de_out px=%0d got=%b want=1", i, cap_de[i]); end
            total++; if (cap_rgb[i] !== 24'h0000AA) begin bad++; $display("FAIL first_rgb px=%0d got=%h want=0000aa", i, cap_rgb[i]); end
        end
    endtask

    task automatic test_last_cell();
        logic [23:0] exp;
        run_cells(10'd632, 10'd479, 8);
        total++; if (cap_addr !== 13'd2399) begin bad++; $display("FAIL last_addr got=%0d want=2399", cap_addr); end
        for (int i = 0; i < 8; i++) begin
            exp = (i == 0 || i == 7) ? 24'hFFFFFF : 24'h000000;
            total++; if (cap_rgb[i] !== exp) begin bad++; $display("FAIL glyph81_rgb px=%0d got=%h want=%h", i, cap_rgb[i], exp); end
        end
    endtask

    task automatic test_row_oob();
        run_cells(10'd0, 10'd480, 8);
        total++; if (cap_cre1 !== 1'b0 || cap_are1 !== 1'b0) begin bad++; $display("FAIL oob_re got=%b%b want=00", cap_cre1, cap_are1); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_rgb[i] !== 24'd0) begin bad++; $display("FAIL oob_rgb px=%0d got=%h want=000000", i, cap_rgb[i]); end
        end
    endtask

    task automatic test_off_boundary();
        logic [23:0] exp;
        run_cells(10'd3, 10'd0, 8);
        total++; if (cap_cre1 !== 1'b0) begin bad++; $display("FAIL offb_re got=%b want=0", cap_cre1); end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 5) ? 24'h000000 : 24'h0000AA;
            total++; if (cap_rgb[i] !== exp) begin bad++; $display("FAIL offb_rgb px=%0d got=%h want=%h", i, cap_rgb[i], exp); end
        end
    endtask

    task automatic test_blink();
        logic [23:0] exp;
        run_cells(10'd0, 10'd32, 8);
        for (int i = 0; i < 8; i++) begin
            exp = (i == 0 || i == 7) ? 24'hFFFFFF : 24'h0000AA;
            total++; if (cap_rgb[i] !== exp) begin bad++; $display("FAIL blink_off px=%0d got=%h want=%h", i, cap_rgb[i], exp); end
        end
        pulses(16);
        run_cells(10'd0, 10'd32, 8);
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_rgb[i] !== 24'h0000AA) begin bad++; $display("FAIL blink_on px=%0d got=%h want=0000aa", i, cap_rgb[i]); end
        end
        pulses(16);
        run_cells(10'd0, 10'd32, 8);
        for (int i = 0; i < 8; i++) begin
            exp = (i == 0 || i == 7) ? 24'hFFFFFF : 24'h0000AA;
            total++; if (cap_rgb[i] !== exp) begin bad++; $display("FAIL blink_back px=%0d got=%h want=%h", i, cap_rgb[i], exp); end
        end
    endtask

    task automatic test_cursor();
        cursor_en   = 1'b1;
        cursor_addr = 13'd81;
        run_cells(10'd8, 10'd30, 8);
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_rgb[i] !== 24'hFFFFFF) begin bad++; $display("FAIL cursor_l14 px=%0d got=%h want=ffffff", i, cap_rgb[i]); end
        end
        run_cells(10'd8, 10'd31, 8);
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_rgb[i] !== 24'hFFFFFF) begin bad++; $display("FAIL cursor_l15 px=%0d got=%h want=ffffff", i, cap_rgb[i]); end
        end
        run_cells(10'd8, 10'd29, 8);
        total++; if (cap_rgb[3] !== 24'h0000AA) begin bad++; $display("FAIL cursor_l13 got=%h want=0000aa", cap_rgb[3]); end
        cursor_en = 1'b0;
        run_cells(10'd8, 10'd30, 8);
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_rgb[i] !== 24'h0000AA) begin bad++; $display("FAIL cursor_off px=%0d got=%h want=0000aa", i, cap_rgb[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp;
        run_cells(10'd0, 10'd16, 16);
        for (int i = 0; i < 16; i++) begin
            if (i >= 8)                exp = 24'h0000AA;
            else if (i == 0 || i == 7) exp = 24'hFFFFFF;
            else                       exp = 24'h000000;
            total++; if (cap_rgb[i] !== exp) begin bad++; $display("FAIL b2b_rgb px=%0d got=%h want=%h", i, cap_rgb[i], exp); end
        end
    endtask

    task automatic test_reset_midline();
        logic [23:0] exp;
        de = 1'b1;
        cx = 10'd0;
        cy = 10'd0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_pixel);
            cx = 10'(k);
        end
        total++; if (rgb !== 24'h0000AA) begin bad++; $display("FAIL mid_before got=%h want=0000aa", rgb); end
        #2 rstn = 1'b0;
        #1;
        total++; if (rgb !== 24'd0) begin bad++; $display("FAIL mid_rst_rgb got=%h want=000000", rgb); end
        total++; if (de_out !== 1'b0) begin bad++; $display("FAIL mid_rst_de got=%b want=0", de_out); end
        @(negedge clk_pixel);
        rstn = 1'b1;
        cx   = 10'd8;
        for (int k = 9; k <= 20; k++) begin
            @(negedge clk_pixel);
            exp = (k >= 13) ? 24'h0000AA : 24'h000000;
            total++; if (rgb !== exp) begin bad++; $display("FAIL mid_resume k=%0d got=%h want=%h", k, rgb, exp); end
            if (k < 16) cx = 10'(k);
            else        de = 1'b0;
        end
        idle(4);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rstn        = 1'b0;
        cx          = 10'd0;
        cy          = 10'd0;
        de          = 1'b0;
        vsync_pulse = 1'b0;
        cursor_en   = 1'b0;
        cursor_addr = 13'd0;
        for (int i = 0; i < 8192; i++) begin
            char_mem[i] = 8'h00;
            attr_mem[i] = 8'h00;
        end
        char_mem[0]    = 8'h41; attr_mem[0]    = 8'h1F;
        char_mem[1]    = 8'h41; attr_mem[1]    = 8'h1F;
        char_mem[80]   = 8'h01; attr_mem[80]   = 8'h0F;
        char_mem[81]   = 8'h41; attr_mem[81]   = 8'h1F;
        char_mem[160]  = 8'h01; attr_mem[160]  = 8'h9F;
        char_mem[2399] = 8'h01; attr_mem[2399] = 8'h0F;

        @(negedge clk_pixel);
        test_reset();
        test_first_cell();
        test_last_cell();
        test_row_oob();
        test_off_boundary();
        test_blink();
        test_cursor();
        test_back_to_back();
        test_reset_midline();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
